bsg_mem_1rw_sync_mask_write_bit_client: RTL and testbench

// Requester-side controller for a 1-port synchronous bit-masked RAM: 1-cycle read latency,
// no-change read/write modes. Accepts a valid/ready request stream of masked writes and reads.

---
 rtl/bsg_mem_1rw_sync_mask_write_bit_client.sv | 108 ++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_bit_client.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_client.sv
// Requester-side controller for a 1-port sync bit-masked RAM (1-cycle read).
// Ports: v_i/ready_o/w_i/addr_i/data_i/w_mask_i request in; mem_* RAM port;
//        v_o/data_o/yumi_i read-response out, backed by a credit-checked FIFO.
module bsg_mem_1rw_sync_mask_write_bit_client #(
    parameter int width_p         = 8,
    parameter int els_p           = 16,
    parameter int resp_fifo_els_p = 2,
    localparam int addr_width_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    output logic [width_p-1:0]       mem_w_mask_o,
    input  logic [width_p-1:0]       mem_data_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i
);

    localparam int ptr_w_lp = (resp_fifo_els_p > 1) ? $clog2(resp_fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(resp_fifo_els_p + 1);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(resp_fifo_els_p - 1);
    localparam logic [cnt_w_lp:0]   credits_lp  = (cnt_w_lp + 1)'(resp_fifo_els_p);

    logic [width_p-1:0]  fifo_q [resp_fifo_els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                inflight_q, inflight_d;

    logic                fire;
    logic                empty;
    logic                bypass;
    logic                enq;
    logic                deq;
    logic [cnt_w_lp:0]   used;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_last_lp) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Credits cover both queued data and the read whose data lands next
    // cycle, so a read is only accepted when the FIFO can always hold it.
    assign used    = {1'b0, count_q} + {{cnt_w_lp{1'b0}}, inflight_q};
    assign ready_o = (used < credits_lp);
    assign fire    = v_i & ready_o;

    assign mem_v_o      = fire;
    assign mem_w_o      = w_i;
    assign mem_addr_o   = addr_i;
    assign mem_data_o   = data_i;
    assign mem_w_mask_o = w_mask_i;

    assign empty  = (count_q == '0);
    assign bypass = empty & inflight_q;
    assign v_o    = ~empty | inflight_q;
    assign data_o = empty ? mem_data_i : fifo_q[rptr_q];

    // A bypassed word taken this cycle never needs to be stored.
    assign enq = inflight_q & ~(bypass & yumi_i);
    assign deq = yumi_i & ~empty;

    always_comb begin
        inflight_d = fire & ~w_i;
        rptr_d     = deq ? ptr_inc(rptr_q) : rptr_q;
        wptr_d     = enq ? ptr_inc(wptr_q) : wptr_q;
        count_d    = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inflight_q <= 1'b0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_q[wptr_q] <= mem_data_i;
        end
    end

    yumi_legal: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_client.sv
// Directed bench: two controllers (FIFO depth 2 and depth 1), each on a
// behavioural bit-masked sync RAM; hand-computed expected values.
module tb_bsg_mem_1rw_sync_mask_write_bit_client;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       a_v, a_ready, a_w, a_mv, a_mw, a_vo, a_yumi;
    logic [3:0] a_addr, a_maddr;
    logic [7:0] a_data, a_mask, a_mdata, a_mmask, a_mrd, a_do;

    logic       b_v, b_ready, b_w, b_mv, b_mw, b_vo, b_yumi;
    logic [3:0] b_addr, b_maddr;
    logic [7:0] b_data, b_mask, b_mdata, b_mmask, b_mrd, b_do;

    logic [7:0] ram_a [16];
    logic [7:0] ram_b [16];

    int n_tests = 0;
    int n_fail  = 0;

    bsg_mem_1rw_sync_mask_write_bit_client #(
        .width_p(8), .els_p(16), .resp_fifo_els_p(2)
    ) dut_a (
        .clk_i(clk), .reset_n_i(reset_n),
        .v_i(a_v), .ready_o(a_ready), .w_i(a_w), .addr_i(a_addr),
        .data_i(a_data), .w_mask_i(a_mask),
        .mem_v_o(a_mv), .mem_w_o(a_mw), .mem_addr_o(a_maddr),
        .mem_data_o(a_mdata), .mem_w_mask_o(a_mmask), .mem_data_i(a_mrd),
        .v_o(a_vo), .data_o(a_do), .yumi_i(a_yumi)
    );

    bsg_mem_1rw_sync_mask_write_bit_client #(
        .width_p(8), .els_p(16), .resp_fifo_els_p(1)
    ) dut_b (
        .clk_i(clk), .reset_n_i(reset_n),
        .v_i(b_v), .ready_o(b_ready), .w_i(b_w), .addr_i(b_addr),
        .data_i(b_data), .w_mask_i(b_mask),
        .mem_v_o(b_mv), .mem_w_o(b_mw), .mem_addr_o(b_maddr),
        .mem_data_o(b_mdata), .mem_w_mask_o(b_mmask), .mem_data_i(b_mrd),
        .v_o(b_vo), .data_o(b_do), .yumi_i(b_yumi)
    );

    always @(posedge clk) begin
        if (a_mv) begin
            if (a_mw) ram_a[a_maddr] <= (ram_a[a_maddr] & ~a_mmask) | (a_mdata & a_mmask);
            else      a_mrd <= ram_a[a_maddr];
        end
        if (b_mv) begin
            if (b_mw) ram_b[b_maddr] <= (ram_b[b_maddr] & ~b_mmask) | (b_mdata & b_mmask);
            else      b_mrd <= ram_b[b_maddr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input logic v, input logic w, input logic [3:0] ad,
                         input logic [7:0] d, input logic [7:0] m);
        a_v = v; a_w = w; a_addr = ad; a_data = d; a_mask = m;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit exp_rdy5 [5] = '{1, 1, 0, 0, 0};
        bit exp_mv6  [5] = '{1, 0, 1, 1, 0};
        bit exp_rdy6 [5] = '{1, 0, 1, 1, 0};
        bit exp_vo6  [5] = '{0, 1, 0, 0, 1};
        int acc;
        int idx;

        reset_n = 1'b0;
        a_v = 0; a_w = 0; a_addr = 0; a_data = 0; a_mask = 0; a_yumi = 0;
        b_v = 0; b_w = 0; b_addr = 0; b_data = 0; b_mask = 0; b_yumi = 0;
        step(); step();
        check("rst_ready_a", a_ready, 1);
        check("rst_vo_a", a_vo, 0);
        check("rst_mv_a", a_mv, 0);
        check("rst_ready_b", b_ready, 1);
        reset_n = 1'b1;
        step();

        // 1: reset while a read is in flight drops it
        req_a(1, 0, 4'd0, 8'h00, 8'h00);
        check("t1_fire", a_mv, 1);
        step();
        a_v = 0;
        reset_n = 1'b0;
        #1;
        check("t1_rst_vo", a_vo, 0);
        check("t1_rst_ready", a_ready, 1);
        step();
        reset_n = 1'b1;
        step(); step();
        check("t1_no_resp", a_vo, 0);

        // 2: full write then read back
        req_a(1, 1, 4'd3, 8'hA5, 8'hFF);
        check("t2_mv_w", a_mv, 1);
        check("t2_mw_w", a_mw, 1);
        check("t2_maddr", a_maddr, 3);
        check("t2_mdata", a_mdata, 8'hA5);
        step();
        req_a(1, 0, 4'd3, 8'h00, 8'h00);
        check("t2_mw_r", a_mw, 0);
        check("t2_vo_early", a_vo, 0);
        step();
        req_a(0, 0, 4'd0, 8'h00, 8'h00);
        check("t2_vo", a_vo, 1);
        check("t2_data", a_do, 8'hA5);
        a_yumi = 1;
        step();
        a_yumi = 0;
        #1;
        check("t2_vo_after", a_vo, 0);

        // 3: partial mask keeps old upper nibble
        req_a(1, 1, 4'd3, 8'hFF, 8'h0F);
        step();
        req_a(1, 0, 4'd3, 8'h00, 8'h00);
        step();
        req_a(0, 0, 4'd0, 8'h00, 8'h00);
        check("t3_vo", a_vo, 1);
        check("t3_data", a_do, 8'hAF);
        a_yumi = 1;
        step();
        a_yumi = 0;

        // 4: back-to-back reads at full rate
        for (int i = 0; i < 8; i++) begin
            req_a(1, 1, 4'(i), 8'(8'h30 + i), 8'hFF);
            step();
        end
        for (int k = 0; k <= 8; k++) begin
            req_a(k < 8, 0, 4'(k), 8'h00, 8'h00);
            if (k < 8) check("t4_ready", a_ready, 1);
            if (k > 0) begin
                check("t4_vo", a_vo, 1);
                check("t4_data", a_do, 8'(8'h30 + k - 1));
            end
            a_yumi = a_vo;
            step();
        end
        a_yumi = 0;
        req_a(0, 0, 4'd0, 8'h00, 8'h00);
        check("t4_idle", a_vo, 0);

        // 5: consumer stall, credits stop acceptance at two
        acc = 0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            req_a(1, 0, 4'(idx), 8'h00, 8'h00);
            check("t5_ready", a_ready, 32'(exp_rdy5[c]));
            if (a_mv) begin
                acc++;
                idx++;
            end
            step();
        end
        check("t5_accepted", acc, 2);
        req_a(0, 0, 4'd0, 8'h00, 8'h00);
        check("t5_vo0", a_vo, 1);
        check("t5_data0", a_do, 8'h30);
        check("t5_ready_hold", a_ready, 0);
        a_yumi = 1;
        step();
        check("t5_ready_free", a_ready, 1);
        check("t5_vo1", a_vo, 1);
        check("t5_data1", a_do, 8'h31);
        step();
        a_yumi = 0;
        #1;
        check("t5_drained", a_vo, 0);

        // 6: depth-1 controller, reads and writes share credits
        b_v = 1; b_w = 1; b_addr = 4'd5; b_data = 8'h3C; b_mask = 8'hFF;
        #1;
        check("t6_preload", b_mv, 1);
        step();
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            case (idx)
                0: begin b_v = 1; b_w = 0; b_addr = 4'd5; b_data = 8'h00; end
                1: begin b_v = 1; b_w = 1; b_addr = 4'd6; b_data = 8'h5A; end
                2: begin b_v = 1; b_w = 0; b_addr = 4'd6; b_data = 8'h00; end
                default: b_v = 0;
            endcase
            b_mask = 8'hFF;
            #1;
            check("t6_mv", b_mv, 32'(exp_mv6[c]));
            check("t6_ready", b_ready, 32'(exp_rdy6[c]));
            check("t6_vo", b_vo, 32'(exp_vo6[c]));
            if (c == 1) check("t6_data_a5", b_do, 8'h3C);
            if (c == 4) check("t6_data_a6", b_do, 8'h5A);
            b_yumi = b_vo;
            if (b_mv) idx++;
            step();
        end
        b_yumi = 0;
        b_v = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
